// File: rtl/mips_control_unit.sv
// Multicycle Moore control unit for the MIPS datapath.
// State, wait counter and exception code are registered. Control outputs are
// decoded from the registered state. EQ and O only matter in BRANCH and in
// EXEC_R/EXEC_I.
//
// state      | meaning
// RESET      | sp <= 227, then start fetching
// FETCH      | drive PC to memory, ALU computes PC+4
// FETCH_WAIT | hold the fetch while memory settles
// IR_LOAD    | capture IR, PC <= PC+4
// DECODE     | ALUOut <= branch target, dispatch on opcode/funct
// EXEC_R     | R-type ALU op, overflow check for add/sub
// WB_R       | rd <= ALUOut
// EXEC_I     | addi, overflow check
// WB_I       | rt <= ALUOut
// ADDR       | ALUOut <= A + SE16 (load/store address)
// MEM_RD     | hold data address for the read
// WB_LW      | rt <= loaded word
// MEM_WR     | single write strobe
// BRANCH     | compare A/B, conditionally PC <= ALUOut
// LUI        | rt <= imm << 16
// JUMP       | PC <= jump target
// JAL        | ALUOut <= PC (return address)
// JAL_WB     | ra <= ALUOut, PC <= jump target
// JR         | PC <= A
// EXC        | EPC <= PC-4, present exception vector address
// EXC_WAIT   | hold vector address while memory settles
// EXC_LOAD   | PC <= handler address read from the vector
module mips_control_unit #(
  parameter int MEM_WAIT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       O,
  input  logic       EQ,
  output logic [1:0] excpControl,
  output logic [1:0] iord,
  output logic       memWrite,
  output logic       irWrite,
  output logic       regWrite,
  output logic [2:0] srcWrite,
  output logic [3:0] srcData,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [2:0] aluControl,
  output logic       aluOutControl,
  output logic [2:0] pcSource,
  output logic       pcWrite,
  output logic       epcControl,
  output logic [1:0] lsControl,
  output logic [4:0] state
);

  typedef enum logic [4:0] {
    S_RESET      = 5'd0,
    S_FETCH      = 5'd1,
    S_FETCH_WAIT = 5'd2,
    S_IR_LOAD    = 5'd3,
    S_DECODE     = 5'd4,
    S_EXEC_R     = 5'd5,
    S_WB_R       = 5'd6,
    S_EXEC_I     = 5'd7,
    S_WB_I       = 5'd8,
    S_ADDR       = 5'd9,
    S_MEM_RD     = 5'd10,
    S_WB_LW      = 5'd11,
    S_MEM_WR     = 5'd12,
    S_BRANCH     = 5'd13,
    S_LUI        = 5'd14,
    S_JUMP       = 5'd15,
    S_JAL        = 5'd16,
    S_JAL_WB     = 5'd17,
    S_JR         = 5'd18,
    S_EXC        = 5'd19,
    S_EXC_WAIT   = 5'd20,
    S_EXC_LOAD   = 5'd21
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LUI  = 6'h0f;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;

  // FETCH already counts as the first memory cycle, so FETCH_WAIT is one shorter.
  localparam logic [3:0] FW_LOAD = 4'(MEM_WAIT - 2);
  localparam logic [3:0] MW_LOAD = 4'(MEM_WAIT - 1);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic [1:0] r_code;
  logic       w_add_sub;
  logic       w_take;

  assign w_add_sub = (funct == FN_ADD) || (funct == FN_SUB);
  assign w_take    = ((opcode == OP_BEQ) && EQ) || ((opcode == OP_BNE) && !EQ);
  assign state     = r_state;

  // State sequencing, memory-wait down-counter and exception-code latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RESET;
      r_cnt   <= '0;
      r_code  <= '0;
    end else begin
      case (r_state)
        S_RESET: r_state <= S_FETCH;
        S_FETCH: begin
          if (MEM_WAIT > 1) begin
            r_state <= S_FETCH_WAIT;
            r_cnt   <= FW_LOAD;
          end else begin
            r_state <= S_IR_LOAD;
          end
        end
        S_FETCH_WAIT: begin
          if (r_cnt == 4'd0) r_state <= S_IR_LOAD;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        S_IR_LOAD: r_state <= S_DECODE;
        S_DECODE: begin
          r_code <= 2'd0;
          case (opcode)
            OP_R: begin
              if (w_add_sub || (funct == FN_AND)) r_state <= S_EXEC_R;
              else if (funct == FN_JR)            r_state <= S_JR;
              else                                r_state <= S_EXC;
            end
            OP_ADDI:       r_state <= S_EXEC_I;
            OP_LW, OP_SW:  r_state <= S_ADDR;
            OP_BEQ, OP_BNE: r_state <= S_BRANCH;
            OP_LUI:        r_state <= S_LUI;
            OP_J:          r_state <= S_JUMP;
            OP_JAL:        r_state <= S_JAL;
            default:       r_state <= S_EXC;
          endcase
        end
        S_EXEC_R: begin
          if (O && w_add_sub) begin
            r_state <= S_EXC;
            r_code  <= 2'd1;
          end else begin
            r_state <= S_WB_R;
          end
        end
        S_EXEC_I: begin
          if (O) begin
            r_state <= S_EXC;
            r_code  <= 2'd1;
          end else begin
            r_state <= S_WB_I;
          end
        end
        S_ADDR: begin
          if (opcode == OP_LW) begin
            r_state <= S_MEM_RD;
            r_cnt   <= MW_LOAD;
          end else begin
            r_state <= S_MEM_WR;
          end
        end
        S_MEM_RD: begin
          if (r_cnt == 4'd0) r_state <= S_WB_LW;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        S_JAL: r_state <= S_JAL_WB;
        S_EXC: begin
          r_state <= S_EXC_WAIT;
          r_cnt   <= MW_LOAD;
        end
        S_EXC_WAIT: begin
          if (r_cnt == 4'd0) r_state <= S_EXC_LOAD;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        S_WB_R, S_WB_I, S_WB_LW, S_MEM_WR, S_BRANCH, S_LUI,
        S_JUMP, S_JAL_WB, S_JR, S_EXC_LOAD: r_state <= S_FETCH;
        default: r_state <= S_RESET;
      endcase
    end
  end

  // Control-word decode of the current state.
  always_comb begin
    excpControl   = 2'd0;
    iord          = 2'd0;
    memWrite      = 1'b0;
    irWrite       = 1'b0;
    regWrite      = 1'b0;
    srcWrite      = 3'd0;
    srcData       = 4'd0;
    aluSrcA       = 2'd0;
    aluSrcB       = 2'd0;
    aluControl    = 3'b000;
    aluOutControl = 1'b0;
    pcSource      = 3'd0;
    pcWrite       = 1'b0;
    epcControl    = 1'b0;
    lsControl     = 2'd0;
    case (r_state)
      S_RESET: begin regWrite = 1'b1; srcWrite = 3'd2; srcData = 4'd8; end
      S_FETCH, S_FETCH_WAIT: begin aluSrcB = 2'd1; aluControl = 3'b001; end
      S_IR_LOAD: begin
        irWrite = 1'b1; pcWrite = 1'b1; aluSrcB = 2'd1; aluControl = 3'b001;
      end
      S_DECODE: begin aluSrcB = 2'd3; aluControl = 3'b001; aluOutControl = 1'b1; end
      S_EXEC_R: begin
        aluSrcA = 2'd1; aluOutControl = 1'b1;
        case (funct)
          FN_SUB:  aluControl = 3'b010;
          FN_AND:  aluControl = 3'b011;
          default: aluControl = 3'b001;
        endcase
      end
      S_WB_R: begin regWrite = 1'b1; srcWrite = 3'd1; end
      S_EXEC_I, S_ADDR: begin
        aluSrcA = 2'd1; aluSrcB = 2'd2; aluControl = 3'b001; aluOutControl = 1'b1;
      end
      S_WB_I:   regWrite = 1'b1;
      S_MEM_RD: iord = 2'd1;
      S_WB_LW:  begin regWrite = 1'b1; srcData = 4'd1; end
      S_MEM_WR: begin iord = 2'd1; memWrite = 1'b1; end
      S_BRANCH: begin
        aluSrcA = 2'd1; aluControl = 3'b111;
        pcWrite = w_take; pcSource = w_take ? 3'd1 : 3'd0;
      end
      S_LUI:  begin regWrite = 1'b1; srcData = 4'd5; end
      S_JUMP: begin pcWrite = 1'b1; pcSource = 3'd2; end
      S_JAL:  aluOutControl = 1'b1;
      S_JAL_WB: begin
        regWrite = 1'b1; srcWrite = 3'd4; pcWrite = 1'b1; pcSource = 3'd2;
      end
      S_JR: begin aluSrcA = 2'd1; pcWrite = 1'b1; end
      S_EXC: begin
        aluSrcB = 2'd1; aluControl = 3'b010; epcControl = 1'b1;
        iord = 2'd2; excpControl = r_code;
      end
      S_EXC_WAIT: begin iord = 2'd2; excpControl = r_code; end
      S_EXC_LOAD: begin lsControl = 2'd2; pcSource = 3'd4; pcWrite = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_control_unit.sv
// Testbench for mips_control_unit: per-instruction tables of expected control
// words, queued when an instruction is driven and compared cycle by cycle.
module tb_mips_control_unit;

  typedef struct packed {
    logic [1:0] excp;
    logic [1:0] iord;
    logic       memw;
    logic       irw;
    logic       regw;
    logic [2:0] srcw;
    logic [3:0] srcd;
    logic [1:0] asa;
    logic [1:0] asb;
    logic [2:0] aluc;
    logic       aoc;
    logic [2:0] pcs;
    logic       pcw;
    logic       epc;
    logic [1:0] ls;
  } ctrl_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       o;
    logic       eq;
    int         n;
    ctrl_t      seq[10];
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic [5:0] opcode, funct;
  logic O, EQ;
  logic [1:0] excpControl, iord, aluSrcA, aluSrcB, lsControl;
  logic memWrite, irWrite, regWrite, aluOutControl, pcWrite, epcControl;
  logic [2:0] srcWrite, aluControl, pcSource;
  logic [3:0] srcData;
  logic [4:0] state;

  int n_vec = 0;
  int n_err = 0;
  ctrl_t q[$];
  vec_t  vecs[16];
  int    n_vecs = 0;
  vec_t  cur;

  mips_control_unit #(.MEM_WAIT(2)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .O(O), .EQ(EQ),
    .excpControl(excpControl), .iord(iord), .memWrite(memWrite), .irWrite(irWrite),
    .regWrite(regWrite), .srcWrite(srcWrite), .srcData(srcData), .aluSrcA(aluSrcA),
    .aluSrcB(aluSrcB), .aluControl(aluControl), .aluOutControl(aluOutControl),
    .pcSource(pcSource), .pcWrite(pcWrite), .epcControl(epcControl),
    .lsControl(lsControl), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors, %0d miscompares", n_vec, n_err);
    $fatal(1, "timeout");
  end

  // Expected control words, written directly from the state descriptions.
  function automatic ctrl_t c_reset();
    ctrl_t c = '0; c.regw = 1; c.srcw = 3'd2; c.srcd = 4'd8; return c;
  endfunction
  function automatic ctrl_t c_fetch();
    ctrl_t c = '0; c.asb = 2'd1; c.aluc = 3'b001; return c;
  endfunction
  function automatic ctrl_t c_irload();
    ctrl_t c = c_fetch(); c.irw = 1; c.pcw = 1; return c;
  endfunction
  function automatic ctrl_t c_decode();
    ctrl_t c = '0; c.asb = 2'd3; c.aluc = 3'b001; c.aoc = 1; return c;
  endfunction
  function automatic ctrl_t c_exec_r(input logic [2:0] alu);
    ctrl_t c = '0; c.asa = 2'd1; c.aluc = alu; c.aoc = 1; return c;
  endfunction
  function automatic ctrl_t c_exec_i();
    ctrl_t c = '0; c.asa = 2'd1; c.asb = 2'd2; c.aluc = 3'b001; c.aoc = 1; return c;
  endfunction
  function automatic ctrl_t c_wb(input logic [2:0] w, input logic [3:0] d);
    ctrl_t c = '0; c.regw = 1; c.srcw = w; c.srcd = d; return c;
  endfunction
  function automatic ctrl_t c_memrd();
    ctrl_t c = '0; c.iord = 2'd1; return c;
  endfunction
  function automatic ctrl_t c_memwr();
    ctrl_t c = '0; c.iord = 2'd1; c.memw = 1; return c;
  endfunction
  function automatic ctrl_t c_branch(input logic tk);
    ctrl_t c = '0; c.asa = 2'd1; c.aluc = 3'b111; c.pcw = tk; c.pcs = tk ? 3'd1 : 3'd0; return c;
  endfunction
  function automatic ctrl_t c_jump();
    ctrl_t c = '0; c.pcw = 1; c.pcs = 3'd2; return c;
  endfunction
  function automatic ctrl_t c_jal();
    ctrl_t c = '0; c.aoc = 1; return c;
  endfunction
  function automatic ctrl_t c_jalwb();
    ctrl_t c = c_wb(3'd4, 4'd0); c.pcw = 1; c.pcs = 3'd2; return c;
  endfunction
  function automatic ctrl_t c_jr();
    ctrl_t c = '0; c.asa = 2'd1; c.pcw = 1; return c;
  endfunction
  function automatic ctrl_t c_exc(input logic [1:0] code);
    ctrl_t c = '0; c.asb = 2'd1; c.aluc = 3'b010; c.epc = 1; c.iord = 2'd2; c.excp = code; return c;
  endfunction
  function automatic ctrl_t c_excwait(input logic [1:0] code);
    ctrl_t c = '0; c.iord = 2'd2; c.excp = code; return c;
  endfunction
  function automatic ctrl_t c_excload();
    ctrl_t c = '0; c.ls = 2'd2; c.pcs = 3'd4; c.pcw = 1; return c;
  endfunction

  function automatic ctrl_t dut_ctrl();
    ctrl_t c;
    c.excp = excpControl; c.iord = iord; c.memw = memWrite; c.irw = irWrite;
    c.regw = regWrite; c.srcw = srcWrite; c.srcd = srcData; c.asa = aluSrcA;
    c.asb = aluSrcB; c.aluc = aluControl; c.aoc = aluOutControl; c.pcs = pcSource;
    c.pcw = pcWrite; c.epc = epcControl; c.ls = lsControl;
    return c;
  endfunction

  task automatic chk(input string nm, input ctrl_t exp);
    ctrl_t act;
    act = dut_ctrl();
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got ctrl=%h, expected ctrl=%h", nm, act, exp);
    end
  endtask

  task automatic new_vec(input logic [5:0] op, input logic [5:0] fn, input logic o, input logic eq);
    cur.op = op; cur.fn = fn; cur.o = o; cur.eq = eq;
    cur.seq[0] = c_fetch(); cur.seq[1] = c_fetch();
    cur.seq[2] = c_irload(); cur.seq[3] = c_decode();
    cur.n = 4;
  endtask
  task automatic app(input ctrl_t c);
    cur.seq[cur.n] = c; cur.n++;
  endtask
  task automatic push_vec();
    vecs[n_vecs] = cur; n_vecs++;
  endtask
  task automatic app_exc(input logic [1:0] code);
    app(c_exc(code)); app(c_excwait(code)); app(c_excwait(code)); app(c_excload());
  endtask

  // Drive one instruction (called at the negedge before its FETCH cycle),
  // queue its expected control words, then pop and compare one per cycle.
  task automatic run_vec(input int idx);
    ctrl_t exp;
    opcode = vecs[idx].op; funct = vecs[idx].fn; O = vecs[idx].o; EQ = vecs[idx].eq;
    for (int k = 0; k < vecs[idx].n; k++) q.push_back(vecs[idx].seq[k]);
    for (int k = 0; k < vecs[idx].n; k++) begin
      @(negedge clk);
      if (q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL scoreboard_empty vec%0d cyc%0d: got no entry, expected one", idx, k);
      end else begin
        exp = q.pop_front();
        chk($sformatf("vec%0d op=%h fn=%h cyc%0d", idx, vecs[idx].op, vecs[idx].fn, k), exp);
      end
    end
  endtask

  initial begin
    reset = 1'b1; opcode = '0; funct = '0; O = 1'b0; EQ = 1'b0;

    new_vec(6'h00, 6'h20, 0, 0); app(c_exec_r(3'b001)); app(c_wb(3'd1, 4'd0)); push_vec();
    new_vec(6'h00, 6'h22, 0, 0); app(c_exec_r(3'b010)); app(c_wb(3'd1, 4'd0)); push_vec();
    new_vec(6'h00, 6'h24, 1, 0); app(c_exec_r(3'b011)); app(c_wb(3'd1, 4'd0)); push_vec();
    new_vec(6'h00, 6'h20, 1, 0); app(c_exec_r(3'b001)); app_exc(2'd1); push_vec();
    new_vec(6'h04, 6'h00, 0, 1); app(c_branch(1)); push_vec();
    new_vec(6'h04, 6'h00, 0, 0); app(c_branch(0)); push_vec();
    new_vec(6'h05, 6'h00, 0, 1); app(c_branch(0)); push_vec();
    new_vec(6'h05, 6'h00, 0, 0); app(c_branch(1)); push_vec();
    new_vec(6'h23, 6'h00, 0, 0); app(c_exec_i()); app(c_memrd()); app(c_memrd());
    app(c_wb(3'd0, 4'd1)); push_vec();
    new_vec(6'h2b, 6'h00, 0, 0); app(c_exec_i()); app(c_memwr()); push_vec();
    new_vec(6'h3f, 6'h00, 0, 0); app_exc(2'd0); push_vec();
    new_vec(6'h08, 6'h00, 1, 0); app(c_exec_i()); app_exc(2'd1); push_vec();
    new_vec(6'h08, 6'h00, 0, 0); app(c_exec_i()); app(c_wb(3'd0, 4'd0)); push_vec();
    new_vec(6'h0f, 6'h00, 0, 0); app(c_wb(3'd0, 4'd5)); push_vec();
    new_vec(6'h02, 6'h00, 0, 0); app(c_jump()); push_vec();
    new_vec(6'h03, 6'h00, 0, 0); app(c_jal()); app(c_jalwb()); push_vec();

    // Three reset edges, each shows the stack-pointer init word.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("reset_cycle%0d", i), c_reset());
    end
    reset = 1'b0;
    #1 chk("reset_release_still_reset", c_reset());

    for (int i = 0; i < n_vecs; i++) run_vec(i);

    // jr and an unknown R funct, as a hand sequence.
    new_vec(6'h00, 6'h08, 0, 0); app(c_jr()); vecs[0] = cur; run_vec(0);
    new_vec(6'h00, 6'h2a, 0, 0); app_exc(2'd0); vecs[0] = cur; run_vec(0);

    // Reset in the first MEM_RD cycle of lw: no load write-back may appear.
    opcode = 6'h23; funct = '0; O = 1'b0; EQ = 1'b0;
    for (int k = 0; k < 6; k++) @(negedge clk);
    chk("lw_abort_memrd", c_memrd());
    reset = 1'b1;
    @(negedge clk);
    chk("lw_abort_reset", c_reset());
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_vec++;
      if (regWrite === 1'b1 && srcData === 4'd1) begin
        n_err++;
        $display("FAIL lw_abort_no_wb cyc%0d: got regWrite=1 srcData=1, expected no load write-back", k);
      end
    end
    // Back in the fetch stream: expect IR_LOAD/DECODE of the next fetch by now.
    // Cycles after reset release: FETCH, FETCH_WAIT, IR_LOAD, DECODE.
    chk("lw_abort_recover_decode", c_decode());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
